// File: rtl/ssd_bcd_driver.sv
// Shows a 13-bit binary word on a 4-digit multiplexed seven-segment display.
// Conversion is sequential shift-add-3; only completed results reach the digits.
module ssd_bcd_driver #(
  parameter int REFRESH_BITS = 18,
  parameter bit BLANK_LZ     = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [12:0] value,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic [15:0] bcd,
  output logic        busy,
  output logic        done
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] CONV = 1'b1;

  logic [0:0]              state;
  logic [12:0]             last_value;
  logic [12:0]             shift_bin;
  logic [15:0]             work;
  logic [3:0]              cnt;
  logic [REFRESH_BITS-1:0] refresh;
  logic [1:0]              sel;

  logic [15:0] adj;
  logic [28:0] shifted;
  logic [3:0]  digit;
  logic        blank;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // One double-dabble step: correct every nibble, then shift the 29-bit pair.
  assign adj     = {add3(work[15:12]), add3(work[11:8]), add3(work[7:4]), add3(work[3:0])};
  assign shifted = {adj, shift_bin} << 1;

  assign busy = (state == CONV);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_value <= '0;
      shift_bin  <= '0;
      work       <= '0;
      cnt        <= '0;
      bcd        <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (value != last_value) begin
            shift_bin  <= value;
            last_value <= value;
            work       <= '0;
            cnt        <= '0;
            state      <= CONV;
          end
        end
        CONV: begin
          work      <= shifted[28:13];
          shift_bin <= shifted[12:0];
          cnt       <= cnt + 4'd1;
          if (cnt == 4'd12) begin
            bcd   <= shifted[28:13];
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) refresh <= '0;
    else     refresh <= refresh + 1'b1;
  end

  assign sel = refresh[REFRESH_BITS-1 -: 2];

  // A digit is a leading zero when it and every more significant digit is zero.
  always_comb begin
    digit = 4'd0;
    blank = 1'b0;
    case (sel)
      2'd0: digit = bcd[3:0];
      2'd1: begin
        digit = bcd[7:4];
        blank = BLANK_LZ && (bcd[15:4] == 12'd0);
      end
      2'd2: begin
        digit = bcd[11:8];
        blank = BLANK_LZ && (bcd[15:8] == 8'd0);
      end
      default: begin
        digit = bcd[15:12];
        blank = BLANK_LZ && (bcd[15:12] == 4'd0);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg <= 7'b1111111;
      an  <= 4'b1111;
    end else begin
      an  <= ~(4'b0001 << sel);
      seg <= blank ? 7'b1111111 : decode(digit);
    end
  end

endmodule

// File: tb/tb_ssd_bcd_driver.sv
// Bench for ssd_bcd_driver: vector table, corner-case sequences and a sampled sweep,
// with every done pulse checked against a queue of expected BCD results.
module tb_ssd_bcd_driver;

  localparam int RB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [12:0] value = '0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] bcd;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  ssd_bcd_driver #(.REFRESH_BITS(RB), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst(rst), .value(value), .seg(seg), .an(an),
    .bcd(bcd), .busy(busy), .done(done)
  );

  typedef struct {
    logic [12:0] value;
    logic [15:0] bcd;
    logic [27:0] segs;  // {digit3, digit2, digit1, digit0}
  } vec_t;

  int          tests = 0;
  int          fails = 0;
  int          done_count = 0;
  logic [15:0] exp_q[$];
  vec_t        vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] model_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] model_seg(input logic [15:0] b, input int idx);
    logic [3:0] d;
    logic [15:0] hi;
    hi = b >> (4 * idx);
    d  = hi[3:0];
    if (idx > 0 && hi == 16'd0) return 7'b1111111;
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Scoreboard: each done pulse must carry the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done === 1'b1) begin
      done_count++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected_done: got bcd %0h with nothing expected", bcd);
      end else begin
        check("sb_bcd", {16'd0, bcd}, {16'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic wait_done(input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      step();
      if (done === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n, n1, n2, n_busy, lat, idx, dc0;

    vecs[0] = '{13'd1234, 16'h1234, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}};
    vecs[1] = '{13'd8191, 16'h8191, {7'b0000000, 7'b1111001, 7'b0010000, 7'b1111001}};
    vecs[2] = '{13'd7,    16'h0007, {7'b1111111, 7'b1111111, 7'b1111111, 7'b1111000}};
    vecs[3] = '{13'd1005, 16'h1005, {7'b1111001, 7'b1000000, 7'b1000000, 7'b0010010}};
    vecs[4] = '{13'd100,  16'h0100, {7'b1111111, 7'b1111001, 7'b1000000, 7'b1000000}};
    vecs[5] = '{13'd0,    16'h0000, {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}};

    // Reset state
    repeat (3) step();
    check("rst_seg", {25'd0, seg}, 32'h7f);
    check("rst_an", {28'd0, an}, 32'hf);
    check("rst_bcd", {16'd0, bcd}, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'h0);
    check("rst_done", {31'd0, done}, 32'h0);

    // Idle with value 0: anode scan and single visible zero
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      check("idle_an", {28'd0, an}, {28'd0, ~(4'b0001 << ((k >> 2) & 3))});
      check("idle_seg", {25'd0, seg}, (((k >> 2) & 3) == 0) ? 32'h40 : 32'h7f);
      check("idle_busy_done", {30'd0, busy, done}, 32'h0);
    end
    check("idle_bcd", {16'd0, bcd}, 32'h0);

    // Vector table: latency, busy width, result, pulse width and per-digit display
    for (int t = 0; t < 6; t++) begin
      value = vecs[t].value;
      exp_q.push_back(vecs[t].bcd);
      n_busy = 0;
      lat = -1;
      for (int i = 1; i <= 30; i++) begin
        step();
        if (busy === 1'b1) n_busy++;
        if (done === 1'b1) begin
          lat = i;
          break;
        end
      end
      check("vec_latency", lat, 14);
      check("vec_busy_cycles", n_busy, 13);
      check("vec_bcd", {16'd0, bcd}, {16'd0, vecs[t].bcd});
      step();
      check("vec_done_width", {31'd0, done}, 32'h0);
      step();
      for (int c = 0; c < 16; c++) begin
        step();
        case (an)
          4'b1110: idx = 0;
          4'b1101: idx = 1;
          4'b1011: idx = 2;
          4'b0111: idx = 3;
          default: idx = -1;
        endcase
        if (idx < 0) check("vec_an_onehot", {28'd0, an}, 32'he);
        else check("vec_seg", {25'd0, seg}, {25'd0, vecs[t].segs[idx*7 +: 7]});
      end
    end

    // Value change during a conversion: finish, then restart automatically
    value = 13'd100;
    exp_q.push_back(16'h0100);
    repeat (3) step();
    value = 13'd2500;
    exp_q.push_back(16'h2500);
    wait_done(30, n1);
    check("chg_first_latency", n1, 11);
    check("chg_first_bcd", {16'd0, bcd}, 32'h0100);
    wait_done(30, n2);
    check("chg_gap", n2, 14);
    check("chg_second_bcd", {16'd0, bcd}, 32'h2500);

    // Reset in the middle of a conversion
    step();
    dc0 = done_count;
    value = 13'd4321;
    exp_q.push_back(16'h4321);
    repeat (7) step();
    check("abort_busy_before", {31'd0, busy}, 32'h1);
    rst = 1'b1;
    step();
    check("abort_an", {28'd0, an}, 32'hf);
    check("abort_seg", {25'd0, seg}, 32'h7f);
    check("abort_bcd", {16'd0, bcd}, 32'h0);
    check("abort_busy_done", {30'd0, busy, done}, 32'h0);
    exp_q.delete();
    step();
    check("abort_no_done", done_count, dc0);
    rst = 1'b0;
    exp_q.push_back(16'h4321);
    wait_done(30, n);
    check("abort_restart_latency", n, 14);
    check("abort_restart_bcd", {16'd0, bcd}, 32'h4321);
    step();
    check("abort_done_count", done_count, dc0 + 1);

    // Sampled sweep across the input range against the software model
    for (int v = 0; v <= 8191; v = (v == 8190) ? 8191 : v + 13) begin
      value = 13'(v);
      exp_q.push_back(model_bcd(v));
      wait_done(30, n);
      if (n < 0) check("sweep_timeout", v, 32'hffff_ffff);
      if (v == 8191) break;
    end
    step();
    check("sweep_seg_digit3", {25'd0, model_seg(bcd, 3)}, 32'h00);
    check("sb_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
